// File: rtl/lcd_hd44780_ctrl_pkg.sv
// Shared state encoding, init command table and command helpers
// for the HD44780 character LCD controller.
package lcd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_PWRUP = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_EN_HI = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_WAIT  = 3'd4;
  localparam state_t ST_IDLE  = 3'd5;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Index 0 is sent first: function set, display on, clear, entry mode.
  localparam logic [3:0][7:0] INIT_CMDS = {8'h06, CMD_CLEAR, 8'h0C, 8'h38};

  // Clear, home and their 0x03 alias need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data != 8'd0) && ((data & ~(CMD_CLEAR | CMD_HOME)) == 8'd0);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// Byte-write request channel from the LSU LCD register to the controller.
interface lcd_hd44780_ctrl_if;
  logic       i_req_vld;
  logic       i_req_rs;
  logic [7:0] i_req_data;
  logic       o_req_rdy;

  modport master (output i_req_vld, output i_req_rs, output i_req_data, input o_req_rdy);
  modport slave  (input i_req_vld, input i_req_rs, input i_req_data, output o_req_rdy);
endinterface

// File: rtl/lcd_hd44780_ctrl_tmr.sv
// Loadable down-counter used for every controller delay; zero is high
// while the count reads 0, and the counter never wraps below 0.
module lcd_tmr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// Timed write-only HD44780 controller: runs the power-up init sequence,
// then turns each accepted byte into a setup / EN pulse / hold / wait cycle.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int T_PWRUP      = 750_000,
  parameter int T_SETUP      = 2,
  parameter int T_EN_HI      = 12,
  parameter int T_HOLD       = 2,
  parameter int T_WAIT_SHORT = 2_000,
  parameter int T_WAIT_LONG  = 80_000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  lcd_hd44780_ctrl_if.slave  req,
  output logic               o_init_done,
  output logic               o_lcd_on,
  output logic               o_lcd_blon,
  output logic               o_lcd_rs,
  output logic               o_lcd_rw,
  output logic               o_lcd_en,
  output logic [7:0]         o_lcd_data
);

  localparam int P_MAX = max_int(max_int(max_int(T_PWRUP, T_SETUP), max_int(T_EN_HI, T_HOLD)),
                                 max_int(T_WAIT_SHORT, T_WAIT_LONG));
  localparam int TW = $clog2(P_MAX) + 1;

  localparam logic [TW-1:0] LD_PWRUP      = TW'(T_PWRUP - 1);
  localparam logic [TW-1:0] LD_SETUP      = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] LD_EN_HI      = TW'(T_EN_HI - 1);
  localparam logic [TW-1:0] LD_HOLD       = TW'(T_HOLD - 1);
  localparam logic [TW-1:0] LD_WAIT_SHORT = TW'(T_WAIT_SHORT - 1);
  localparam logic [TW-1:0] LD_WAIT_LONG  = TW'(T_WAIT_LONG - 1);

  if (CLK_HZ < 1 || T_PWRUP < 1 || T_SETUP < 1 || T_EN_HI < 1 || T_HOLD < 1 ||
      T_WAIT_SHORT < 1 || T_WAIT_LONG < 1) begin : g_bad_param
    $error("lcd_hd44780_ctrl: clock and timing parameters must be >= 1");
  end

  state_t          state;
  logic [1:0]      init_idx;
  logic [1:0]      nxt_idx;
  logic            req_rdy;
  logic            accept;
  logic            init_more;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_zero;

  assign accept        = req.i_req_vld && req_rdy;
  assign init_more     = !o_init_done && (init_idx != 2'd3);
  assign nxt_idx       = init_idx + 2'd1;
  assign req.o_req_rdy = req_rdy;
  assign o_lcd_rw      = 1'b0;

  lcd_tmr #(.W(TW)) u_tmr (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Every state entry reloads the timer with its length minus one; the very
  // first cycle after reset (lcd_on still low) arms the power-up wait.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_PWRUP: begin
        if (!o_lcd_on) begin
          tmr_load = 1'b1;
          tmr_val  = LD_PWRUP;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        tmr_load = tmr_zero;
        tmr_val  = LD_EN_HI;
      end
      ST_EN_HI: begin
        tmr_load = tmr_zero;
        tmr_val  = LD_HOLD;
      end
      ST_HOLD: begin
        tmr_load = tmr_zero;
        tmr_val  = is_long_cmd(o_lcd_rs, o_lcd_data) ? LD_WAIT_LONG : LD_WAIT_SHORT;
      end
      ST_WAIT: begin
        tmr_load = tmr_zero && init_more;
        tmr_val  = LD_SETUP;
      end
      ST_IDLE: begin
        tmr_load = accept;
        tmr_val  = LD_SETUP;
      end
      default: begin
        tmr_load = 1'b0;
        tmr_val  = '0;
      end
    endcase
  end

  // RS/DATA pins are the latched byte itself, so they stay put through
  // EN, hold, wait and idle until the next byte is loaded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_PWRUP;
      init_idx    <= 2'd0;
      req_rdy     <= 1'b0;
      o_init_done <= 1'b0;
      o_lcd_on    <= 1'b0;
      o_lcd_blon  <= 1'b0;
      o_lcd_rs    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_data  <= 8'd0;
    end else begin
      case (state)
        ST_PWRUP: begin
          if (!o_lcd_on) begin
            o_lcd_on   <= 1'b1;
            o_lcd_blon <= 1'b1;
          end else if (tmr_zero) begin
            init_idx   <= 2'd0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= INIT_CMDS[0];
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_zero) begin
            o_lcd_en <= 1'b1;
            state    <= ST_EN_HI;
          end
        end
        ST_EN_HI: begin
          if (tmr_zero) begin
            o_lcd_en <= 1'b0;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tmr_zero) begin
            if (init_more) begin
              init_idx   <= nxt_idx;
              o_lcd_data <= INIT_CMDS[nxt_idx];
              state      <= ST_SETUP;
            end else begin
              o_init_done <= 1'b1;
              req_rdy     <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (accept) begin
            o_lcd_rs   <= req.i_req_rs;
            o_lcd_data <= req.i_req_data;
            req_rdy    <= 1'b0;
            state      <= ST_SETUP;
          end
        end
        default: begin
          state <= ST_PWRUP;
        end
      endcase
    end
  end

endmodule
